// File: rtl/fft_frame_sequencer.sv
// fft_frame_sequencer: frame controller that gates ADC samples into an FFT core and tracks the peak bin.
// Ports:
//   clk, reset_n                      clock, asynchronous active-low reset
//   enable_i                          run frames continuously while high
//   adc_valid_i, adc_data_i[11:0]     ADC sample strobe and raw sample (bit 11 = sign)
//   fft_active_o, fft_real_o[15:0]    sample stream into the core, one cycle after acceptance
//   fft_reset_o                       core reset, high in IDLE and CLR
//   fft_done_i                        core has finished the transform
//   mag_ready_i, mag_i[15:0]          magnitude stream from the core, one pulse per bin
//   peak_bin_o, peak_mag_o            peak of the last completed frame
//   frame_valid_o                     one-cycle pulse when the peak outputs update
//   frame_count_o                     completed frames, wrapping
//   dropped_o                         samples arriving outside FILL, saturating
//   busy_o, error_o                   not idle; sticky watchdog flag
module fft_frame_sequencer #(
    parameter int FFT_LENGTH     = 1024,
    parameter int IDX_W          = 10,
    parameter int RST_CYCLES     = 4,
    parameter int TIMEOUT_CYCLES = 65535
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             enable_i,
    input  logic             adc_valid_i,
    input  logic [11:0]      adc_data_i,
    output logic             fft_active_o,
    output logic [15:0]      fft_real_o,
    output logic             fft_reset_o,
    input  logic             fft_done_i,
    input  logic             mag_ready_i,
    input  logic [15:0]      mag_i,
    output logic [IDX_W-1:0] peak_bin_o,
    output logic [15:0]      peak_mag_o,
    output logic             frame_valid_o,
    output logic [15:0]      frame_count_o,
    output logic [15:0]      dropped_o,
    output logic             busy_o,
    output logic             error_o
);
    localparam int RW = $clog2(RST_CYCLES + 1);

    typedef enum logic [2:0] {S_IDLE, S_FILL, S_WAIT, S_READ, S_DONE, S_CLR} state_t;

    state_t           r_state, w_next;
    logic [IDX_W-1:0] r_sample_cnt, r_bin_cnt, r_run_bin, r_peak_bin;
    logic [15:0]      r_run_mag, r_peak_mag, r_real, r_frame_cnt, r_dropped, r_wd;
    logic [RW-1:0]    r_rst_cnt;
    logic             r_active, r_frame_valid, r_error;
    logic             w_accept, w_drop, w_in_wd, w_timeout, w_last_sample, w_bin, w_last_bin;
    logic             w_rst_done, w_new_peak, w_clear;

    assign w_accept      = (r_state == S_FILL) && enable_i && adc_valid_i;
    assign w_drop        = adc_valid_i && (r_state != S_FILL);
    assign w_in_wd       = (r_state == S_WAIT) || (r_state == S_READ);
    assign w_timeout     = w_in_wd && (r_wd == 16'(TIMEOUT_CYCLES - 1));
    assign w_last_sample = w_accept && (r_sample_cnt == IDX_W'(FFT_LENGTH - 1));
    assign w_bin         = (r_state == S_READ) && mag_ready_i;
    assign w_last_bin    = w_bin && (r_bin_cnt == IDX_W'(FFT_LENGTH - 1));
    assign w_rst_done    = (r_state == S_CLR) && (r_rst_cnt == RW'(RST_CYCLES - 1));
    assign w_clear       = (r_state == S_CLR) || (r_state == S_IDLE);
    // DC bin and the mirrored upper half never win; strict compare keeps the lowest tied bin
    assign w_new_peak    = w_bin && (r_bin_cnt != '0) && (r_bin_cnt < IDX_W'(FFT_LENGTH / 2))
                           && (mag_i > r_run_mag);

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  w_next = enable_i ? S_FILL : S_IDLE;
            S_FILL:  w_next = !enable_i ? S_CLR : (w_last_sample ? S_WAIT : S_FILL);
            S_WAIT:  w_next = w_timeout ? S_CLR : (fft_done_i ? S_READ : S_WAIT);
            S_READ:  w_next = w_timeout ? S_CLR : (w_last_bin ? S_DONE : S_READ);
            S_DONE:  w_next = S_CLR;
            S_CLR:   w_next = w_rst_done ? (enable_i ? S_FILL : S_IDLE) : S_CLR;
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state       <= S_IDLE;
            r_active      <= 1'b0;
            r_real        <= '0;
            r_sample_cnt  <= '0;
            r_bin_cnt     <= '0;
            r_run_bin     <= '0;
            r_run_mag     <= '0;
            r_peak_bin    <= '0;
            r_peak_mag    <= '0;
            r_frame_valid <= 1'b0;
            r_frame_cnt   <= '0;
            r_dropped     <= '0;
            r_wd          <= '0;
            r_rst_cnt     <= '0;
            r_error       <= 1'b0;
        end else begin
            r_state      <= w_next;
            r_active     <= w_accept;
            if (w_accept)
                r_real <= {adc_data_i[11], 4'b0000, adc_data_i[10:0]};
            r_sample_cnt <= w_clear ? '0 : r_sample_cnt + IDX_W'(w_accept);
            r_bin_cnt    <= w_clear ? '0 : r_bin_cnt + IDX_W'(w_bin);
            if (w_clear) begin
                r_run_bin <= '0;
                r_run_mag <= '0;
            end else if (w_new_peak) begin
                r_run_bin <= r_bin_cnt;
                r_run_mag <= mag_i;
            end
            // watchdog restarts from zero on every entry to WAIT_FFT
            r_wd          <= w_in_wd ? r_wd + 16'd1 : '0;
            r_rst_cnt     <= (r_state == S_CLR) ? r_rst_cnt + 1'b1 : '0;
            r_frame_valid <= (r_state == S_DONE);
            if (r_state == S_DONE) begin
                r_peak_bin  <= r_run_bin;
                r_peak_mag  <= r_run_mag;
                r_frame_cnt <= r_frame_cnt + 16'd1;
            end
            if (w_drop && (r_dropped != 16'hFFFF))
                r_dropped <= r_dropped + 16'd1;
            if (w_timeout)
                r_error <= 1'b1;
        end
    end

    assign fft_active_o  = r_active;
    assign fft_real_o    = r_real;
    assign fft_reset_o   = (r_state == S_IDLE) || (r_state == S_CLR);
    assign peak_bin_o    = r_peak_bin;
    assign peak_mag_o    = r_peak_mag;
    assign frame_valid_o = r_frame_valid;
    assign frame_count_o = r_frame_cnt;
    assign dropped_o     = r_dropped;
    assign busy_o        = (r_state != S_IDLE);
    assign error_o       = r_error;
endmodule

// File: tb/tb_fft_frame_sequencer.sv
// tb_fft_frame_sequencer: directed bench for fft_frame_sequencer (main instance plus a short-watchdog instance).
module tb_fft_frame_sequencer;
    logic        clk = 1'b0, reset_n = 1'b0, enable_i = 1'b0, adc_valid_i = 1'b0;
    logic        fft_done_i = 1'b0, mag_ready_i = 1'b0;
    logic [11:0] adc_data_i = '0;
    logic [15:0] mag_i = '0;

    logic        fft_active_o, fft_reset_o, frame_valid_o, busy_o, error_o;
    logic [15:0] fft_real_o, peak_mag_o, frame_count_o, dropped_o;
    logic [9:0]  peak_bin_o;

    logic        t_active, t_reset, t_fv, t_busy, t_error;
    logic [15:0] t_real, t_peak_mag, t_frame_count, t_dropped;
    logic [9:0]  t_peak_bin;

    int          total = 0, bad = 0;
    int          act_cnt = 0, fv_cnt = 0, fv2_cnt = 0;
    logic [15:0] last_real = '0;
    logic [15:0] mags [1024];

    fft_frame_sequencer dut (
        .clk(clk), .reset_n(reset_n), .enable_i(enable_i), .adc_valid_i(adc_valid_i),
        .adc_data_i(adc_data_i), .fft_active_o(fft_active_o), .fft_real_o(fft_real_o),
        .fft_reset_o(fft_reset_o), .fft_done_i(fft_done_i), .mag_ready_i(mag_ready_i),
        .mag_i(mag_i), .peak_bin_o(peak_bin_o), .peak_mag_o(peak_mag_o),
        .frame_valid_o(frame_valid_o), .frame_count_o(frame_count_o), .dropped_o(dropped_o),
        .busy_o(busy_o), .error_o(error_o)
    );

    fft_frame_sequencer #(.TIMEOUT_CYCLES(100)) dut_wd (
        .clk(clk), .reset_n(reset_n), .enable_i(enable_i), .adc_valid_i(adc_valid_i),
        .adc_data_i(adc_data_i), .fft_active_o(t_active), .fft_real_o(t_real),
        .fft_reset_o(t_reset), .fft_done_i(fft_done_i), .mag_ready_i(mag_ready_i),
        .mag_i(mag_i), .peak_bin_o(t_peak_bin), .peak_mag_o(t_peak_mag),
        .frame_valid_o(t_fv), .frame_count_o(t_frame_count), .dropped_o(t_dropped),
        .busy_o(t_busy), .error_o(t_error)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (fft_active_o) begin
            act_cnt++;
            last_real = fft_real_o;
        end
        if (frame_valid_o) fv_cnt++;
        if (t_fv) fv2_cnt++;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_samples(input int n, input logic [11:0] d);
        for (int i = 0; i < n; i++) begin
            adc_valid_i = 1'b1;
            adc_data_i  = d;
            tick();
        end
        adc_valid_i = 1'b0;
    endtask

    task automatic set_ramp(input int peak_idx);
        for (int i = 0; i < 1024; i++) mags[i] = 16'(i);
        mags[peak_idx] = 16'h7FFF;
    endtask

    task automatic set_zero();
        for (int i = 0; i < 1024; i++) mags[i] = 16'h0000;
    endtask

    task automatic readout(input int n);
        fft_done_i = 1'b1;
        tick();
        fft_done_i = 1'b0;
        for (int i = 0; i < n; i++) begin
            mag_ready_i = 1'b1;
            mag_i       = mags[i];
            tick();
        end
        mag_ready_i = 1'b0;
    endtask

    task automatic test_reset();
        tick();
        tick();
        total++; if (fft_reset_o !== 1'b1) begin bad++; $display("FAIL reset_fft_reset: got %b want 1", fft_reset_o); end
        total++; if (busy_o !== 1'b0) begin bad++; $display("FAIL reset_busy: got %b want 0", busy_o); end
        total++; if (fft_active_o !== 1'b0) begin bad++; $display("FAIL reset_active: got %b want 0", fft_active_o); end
        total++; if (frame_count_o !== 16'h0) begin bad++; $display("FAIL reset_frame_count: got %h want 0", frame_count_o); end
        total++; if (dropped_o !== 16'h0) begin bad++; $display("FAIL reset_dropped: got %h want 0", dropped_o); end
        total++; if (error_o !== 1'b0) begin bad++; $display("FAIL reset_error: got %b want 0", error_o); end
        total++; if ({peak_bin_o, peak_mag_o} !== 26'h0) begin bad++; $display("FAIL reset_peak: got %h/%h want 0/0", peak_bin_o, peak_mag_o); end
        reset_n = 1'b1;
        tick();
    endtask

    task automatic test_peak_ramp();
        int a0, f0;
        a0 = act_cnt;
        f0 = fv_cnt;
        set_ramp(37);
        enable_i = 1'b1;
        tick();
        total++; if (fft_reset_o !== 1'b0 || busy_o !== 1'b1) begin bad++; $display("FAIL fill_entry: got reset=%b busy=%b want 0/1", fft_reset_o, busy_o); end
        send_samples(1024, 12'h005);
        total++; if (last_real !== 16'h0005) begin bad++; $display("FAIL ramp_real: got %h want 0005", last_real); end
        readout(1024);
        tick();
        total++; if (frame_valid_o !== 1'b1) begin bad++; $display("FAIL ramp_frame_valid: got %b want 1", frame_valid_o); end
        total++; if (peak_bin_o !== 10'd37) begin bad++; $display("FAIL ramp_peak_bin: got %0d want 37", peak_bin_o); end
        total++; if (peak_mag_o !== 16'h7FFF) begin bad++; $display("FAIL ramp_peak_mag: got %h want 7fff", peak_mag_o); end
        total++; if (frame_count_o !== 16'd1) begin bad++; $display("FAIL ramp_frame_count: got %0d want 1", frame_count_o); end
        total++; if (act_cnt - a0 !== 1024) begin bad++; $display("FAIL ramp_active_pulses: got %0d want 1024", act_cnt - a0); end
        repeat (4) tick();
        total++; if (fv_cnt - f0 !== 1) begin bad++; $display("FAIL ramp_valid_pulses: got %0d want 1", fv_cnt - f0); end
        total++; if (fft_reset_o !== 1'b0 || busy_o !== 1'b1) begin bad++; $display("FAIL ramp_refill: got reset=%b busy=%b want 0/1", fft_reset_o, busy_o); end
    endtask

    task automatic test_peak_ties();
        set_zero();
        mags[0]   = 16'hFFFF;
        mags[600] = 16'hFFFF;
        mags[10]  = 16'h1234;
        mags[20]  = 16'h1234;
        send_samples(1024, 12'h7FF);
        total++; if (last_real !== 16'h07FF) begin bad++; $display("FAIL ties_real: got %h want 07ff", last_real); end
        readout(1024);
        tick();
        total++; if (peak_bin_o !== 10'd10) begin bad++; $display("FAIL ties_peak_bin: got %0d want 10", peak_bin_o); end
        total++; if (peak_mag_o !== 16'h1234) begin bad++; $display("FAIL ties_peak_mag: got %h want 1234", peak_mag_o); end
        total++; if (frame_count_o !== 16'd2) begin bad++; $display("FAIL ties_frame_count: got %0d want 2", frame_count_o); end
        repeat (4) tick();
    endtask

    task automatic test_drops();
        int a0;
        set_zero();
        send_samples(1024, 12'h805);
        total++; if (last_real !== 16'h8005) begin bad++; $display("FAIL drops_real_sign: got %h want 8005", last_real); end
        send_samples(5, 12'h111);
        readout(1024);
        tick();
        total++; if ({peak_bin_o, peak_mag_o} !== 26'h0) begin bad++; $display("FAIL zero_peak: got %0d/%h want 0/0", peak_bin_o, peak_mag_o); end
        total++; if (frame_count_o !== 16'd3) begin bad++; $display("FAIL drops_frame_count: got %0d want 3", frame_count_o); end
        send_samples(3, 12'h222);
        tick();
        total++; if (dropped_o !== 16'd8) begin bad++; $display("FAIL dropped_8: got %0d want 8", dropped_o); end
        a0 = act_cnt;
        set_ramp(37);
        send_samples(1023, 12'h001);
        total++; if (dropped_o !== 16'd8) begin bad++; $display("FAIL fill_1023: got dropped %0d want 8", dropped_o); end
        send_samples(1, 12'h001);
        send_samples(1, 12'h001);
        total++; if (dropped_o !== 16'd9) begin bad++; $display("FAIL fill_1025th_dropped: got %0d want 9", dropped_o); end
        total++; if (act_cnt - a0 !== 1024) begin bad++; $display("FAIL fill_exact: got %0d pulses want 1024", act_cnt - a0); end
        readout(1024);
        tick();
        repeat (4) tick();
    endtask

    task automatic test_abort();
        int n, f0;
        logic [15:0] fc0;
        f0  = fv_cnt;
        fc0 = frame_count_o;
        send_samples(500, 12'h123);
        enable_i = 1'b0;
        tick();
        n = 0;
        while (fft_reset_o && busy_o && n < 20) begin
            n++;
            tick();
        end
        total++; if (n !== 4) begin bad++; $display("FAIL abort_clr_cycles: got %0d want 4", n); end
        total++; if (busy_o !== 1'b0 || fft_reset_o !== 1'b1) begin bad++; $display("FAIL abort_idle: got busy=%b reset=%b want 0/1", busy_o, fft_reset_o); end
        total++; if (frame_count_o !== 16'd4 || frame_count_o !== fc0) begin bad++; $display("FAIL abort_frame_count: got %0d want 4", frame_count_o); end
        total++; if (fv_cnt !== f0) begin bad++; $display("FAIL abort_valid: got %0d pulses want 0", fv_cnt - f0); end
    endtask

    task automatic test_reset_mid_readout();
        enable_i = 1'b1;
        tick();
        send_samples(1024, 12'h005);
        readout(300);
        #2 reset_n = 1'b0;
        #1;
        total++; if (fft_reset_o !== 1'b1 || busy_o !== 1'b0) begin bad++; $display("FAIL async_reset: got reset=%b busy=%b want 1/0", fft_reset_o, busy_o); end
        total++; if ({peak_bin_o, peak_mag_o} !== 26'h0) begin bad++; $display("FAIL async_peak: got %0d/%h want 0/0", peak_bin_o, peak_mag_o); end
        total++; if (frame_count_o !== 16'd0 || dropped_o !== 16'd0) begin bad++; $display("FAIL async_counts: got %0d/%0d want 0/0", frame_count_o, dropped_o); end
        enable_i = 1'b0;
        tick();
        total++; if (fft_reset_o !== 1'b1 || busy_o !== 1'b0) begin bad++; $display("FAIL reset_hold: got reset=%b busy=%b want 1/0", fft_reset_o, busy_o); end
        reset_n = 1'b1;
        tick();
    endtask

    task automatic test_timeout();
        int n, f0;
        f0 = fv2_cnt;
        total++; if (t_error !== 1'b0) begin bad++; $display("FAIL wd_pre: got %b want 0", t_error); end
        enable_i = 1'b1;
        tick();
        send_samples(1024, 12'h005);
        n = 0;
        while (!t_error && n < 300) begin
            n++;
            tick();
        end
        total++; if (n !== 100) begin bad++; $display("FAIL wd_cycles: got %0d want 100", n); end
        total++; if (t_reset !== 1'b1 || t_busy !== 1'b1) begin bad++; $display("FAIL wd_clr: got reset=%b busy=%b want 1/1", t_reset, t_busy); end
        enable_i = 1'b0;
        repeat (4) tick();
        total++; if (t_busy !== 1'b0) begin bad++; $display("FAIL wd_idle: got busy=%b want 0", t_busy); end
        total++; if (t_error !== 1'b1) begin bad++; $display("FAIL wd_sticky: got %b want 1", t_error); end
        total++; if (t_frame_count !== 16'd0 || t_peak_mag !== 16'd0) begin bad++; $display("FAIL wd_no_update: got %0d/%h want 0/0", t_frame_count, t_peak_mag); end
        total++; if (fv2_cnt !== f0) begin bad++; $display("FAIL wd_valid: got %0d pulses want 0", fv2_cnt - f0); end
    endtask

    initial begin
        test_reset();
        test_peak_ramp();
        test_peak_ties();
        test_drops();
        test_abort();
        test_reset_mid_readout();
        test_timeout();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
